// File: rtl/hash_occurr_table.sv
// Hash/occurrence table for the hash core: 1-cycle write-first core access, host clear and dump engines.
// Dump entries stall on dump_ready; define HASH_TABLE_SKIP_EMPTY_EN to skip zero-occurrence entries in a dump.
module hash_occurr_table #(
  parameter int DATA_INDEX_WIDTH = 32,
  parameter int BIT_ON_TAILS     = 7
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BIT_ON_TAILS:0]       HashOccurrAddr,
  output logic [DATA_INDEX_WIDTH-1:0] HashValue,
  output logic [DATA_INDEX_WIDTH-1:0] OccurrValue,
  input  logic                        WrEn,
  input  logic [DATA_INDEX_WIDTH-1:0] NewHashValue,
  input  logic [DATA_INDEX_WIDTH-1:0] NewOccurrValue,
  output logic                        table_ready,
  input  logic                        clear_req,
  input  logic                        dump_req,
  output logic                        dump_valid,
  input  logic                        dump_ready,
  output logic [BIT_ON_TAILS:0]       dump_addr,
  output logic [DATA_INDEX_WIDTH-1:0] dump_hash,
  output logic [DATA_INDEX_WIDTH-1:0] dump_occurr,
  output logic                        dump_done
);
  localparam int ADDR_W = BIT_ON_TAILS + 1;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {CLEAR, IDLE, DUMP_RD, DUMP_OUT} state_t;

  state_t                      state, state_nxt;
  logic [ADDR_W-1:0]           ptr, ptr_nxt;
  logic [DATA_INDEX_WIDTH-1:0] hash_mem   [DEPTH];
  logic [DATA_INDEX_WIDTH-1:0] occurr_mem [DEPTH];

  logic                        mem_we;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_INDEX_WIDTH-1:0] mem_hash_dat, mem_occurr_dat;
  logic [DATA_INDEX_WIDTH-1:0] rd_hash, rd_occurr;

  logic [DATA_INDEX_WIDTH-1:0] hash_value_nxt, occurr_value_nxt;
  logic                        dump_valid_nxt, dump_done_nxt;
  logic [ADDR_W-1:0]           dump_addr_nxt;
  logic [DATA_INDEX_WIDTH-1:0] dump_hash_nxt, dump_occurr_nxt;

  // One shared address: the core owns it in IDLE, the clear/dump pointer otherwise.
  always_comb begin
    mem_addr       = (state == IDLE) ? HashOccurrAddr : ptr;
    mem_we         = (state == CLEAR) || ((state == IDLE) && WrEn);
    mem_hash_dat   = (state == IDLE) ? NewHashValue   : '0;
    mem_occurr_dat = (state == IDLE) ? NewOccurrValue : '0;
    // Write-first bypass: read and write always share the address.
    rd_hash        = mem_we ? mem_hash_dat   : hash_mem[mem_addr];
    rd_occurr      = mem_we ? mem_occurr_dat : occurr_mem[mem_addr];
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      hash_mem[mem_addr]   <= mem_hash_dat;
      occurr_mem[mem_addr] <= mem_occurr_dat;
    end
  end

  assign table_ready = (state == IDLE);

  always_comb begin
    state_nxt        = state;
    ptr_nxt          = ptr;
    hash_value_nxt   = HashValue;
    occurr_value_nxt = OccurrValue;
    dump_valid_nxt   = dump_valid;
    dump_addr_nxt    = dump_addr;
    dump_hash_nxt    = dump_hash;
    dump_occurr_nxt  = dump_occurr;
    dump_done_nxt    = 1'b0;
    case (state)
      CLEAR: begin
        ptr_nxt = ptr + ADDR_W'(1);
        if (ptr == PTR_LAST) state_nxt = IDLE;
      end
      IDLE: begin
        hash_value_nxt   = rd_hash;
        occurr_value_nxt = rd_occurr;
        if (clear_req) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end else if (dump_req) begin
          state_nxt = DUMP_RD;
          ptr_nxt   = '0;
        end
      end
      DUMP_RD: begin
`ifdef HASH_TABLE_SKIP_EMPTY_EN
        if (rd_occurr == '0) begin
          if (ptr == PTR_LAST) begin
            state_nxt     = IDLE;
            dump_done_nxt = 1'b1;
          end else begin
            ptr_nxt = ptr + ADDR_W'(1);
          end
        end else begin
          state_nxt       = DUMP_OUT;
          dump_valid_nxt  = 1'b1;
          dump_addr_nxt   = ptr;
          dump_hash_nxt   = rd_hash;
          dump_occurr_nxt = rd_occurr;
        end
`else
        state_nxt       = DUMP_OUT;
        dump_valid_nxt  = 1'b1;
        dump_addr_nxt   = ptr;
        dump_hash_nxt   = rd_hash;
        dump_occurr_nxt = rd_occurr;
`endif
      end
      DUMP_OUT: begin
        if (dump_ready) begin
          dump_valid_nxt = 1'b0;
          if (ptr == PTR_LAST) begin
            state_nxt     = IDLE;
            dump_done_nxt = 1'b1;
          end else begin
            state_nxt = DUMP_RD;
            ptr_nxt   = ptr + ADDR_W'(1);
          end
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= CLEAR;
      ptr         <= '0;
      HashValue   <= '0;
      OccurrValue <= '0;
      dump_valid  <= 1'b0;
      dump_addr   <= '0;
      dump_hash   <= '0;
      dump_occurr <= '0;
      dump_done   <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      HashValue   <= hash_value_nxt;
      OccurrValue <= occurr_value_nxt;
      dump_valid  <= dump_valid_nxt;
      dump_addr   <= dump_addr_nxt;
      dump_hash   <= dump_hash_nxt;
      dump_occurr <= dump_occurr_nxt;
      dump_done   <= dump_done_nxt;
    end
  end
endmodule

// File: tb/tb_hash_occurr_table.sv
// Directed + randomized bench for hash_occurr_table against an array/queue reference model.
module tb_hash_occurr_table;
  localparam int W     = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 256;
`ifdef HASH_TABLE_SKIP_EMPTY_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] HashOccurrAddr = '0;
  logic [W-1:0]  HashValue, OccurrValue;
  logic          WrEn = 1'b0;
  logic [W-1:0]  NewHashValue = '0;
  logic [W-1:0]  NewOccurrValue = '0;
  logic          table_ready;
  logic          clear_req = 1'b0;
  logic          dump_req = 1'b0;
  logic          dump_valid;
  logic          dump_ready = 1'b0;
  logic [AW-1:0] dump_addr;
  logic [W-1:0]  dump_hash, dump_occurr;
  logic          dump_done;

  always #5 clk = ~clk;

  hash_occurr_table #(.DATA_INDEX_WIDTH(W), .BIT_ON_TAILS(AW-1)) dut (
    .clk(clk), .rst(rst), .HashOccurrAddr(HashOccurrAddr),
    .HashValue(HashValue), .OccurrValue(OccurrValue), .WrEn(WrEn),
    .NewHashValue(NewHashValue), .NewOccurrValue(NewOccurrValue),
    .table_ready(table_ready), .clear_req(clear_req), .dump_req(dump_req),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
    .dump_hash(dump_hash), .dump_occurr(dump_occurr), .dump_done(dump_done)
  );

  int tests = 0;
  int fails = 0;
  logic [W-1:0] ref_hash [DEPTH];
  logic [W-1:0] ref_occ  [DEPTH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " HashValue"}, HashValue, 0);
    check({tag, " OccurrValue"}, OccurrValue, 0);
    check({tag, " table_ready"}, table_ready, 0);
    check({tag, " dump_valid"}, dump_valid, 0);
    check({tag, " dump_addr"}, dump_addr, 0);
    check({tag, " dump_hash"}, dump_hash, 0);
    check({tag, " dump_occurr"}, dump_occurr, 0);
    check({tag, " dump_done"}, dump_done, 0);
  endtask

  // Counts edges until the table is usable again; a clear leaves the whole table zero.
  task automatic wait_clear(input string tag);
    int n = 0;
    int vld = 0;
    while (!table_ready && n < 1000) begin
      step();
      n++;
      if (dump_valid) vld++;
    end
    check({tag, " clear cycles"}, n, DEPTH);
    check({tag, " valid during clear"}, vld, 0);
    for (int i = 0; i < DEPTH; i++) begin
      ref_hash[i] = '0;
      ref_occ[i]  = '0;
    end
  endtask

  task automatic access(input logic [AW-1:0] a, input logic we,
                        input logic [W-1:0] h, input logic [W-1:0] o);
    logic [W-1:0] exp_h, exp_o;
    HashOccurrAddr = a;
    WrEn           = we;
    NewHashValue   = h;
    NewOccurrValue = o;
    step();
    WrEn  = 1'b0;
    exp_h = we ? h : ref_hash[a];
    exp_o = we ? o : ref_occ[a];
    check($sformatf("rd hash @%0h", a), HashValue, exp_h);
    check($sformatf("rd occ @%0h", a), OccurrValue, exp_o);
    if (we) begin
      ref_hash[a] = h;
      ref_occ[a]  = o;
    end
  endtask

  task automatic run_dump(input string tag, input bit toggle);
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] a;
    logic [AW-1:0] s_addr;
    logic [W-1:0]  s_hash, s_occ;
    int idx = 0;
    int cyc = 0;
    bit done = 0;
    bit stalled = 0;
    for (int i = 0; i < DEPTH; i++)
      if (!SKIP || ref_occ[i] != '0) exp_q.push_back(AW'(i));
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    check({tag, " ready low in dump"}, table_ready, 0);
    while (!done && cyc < 4000) begin
      dump_ready = toggle ? (((cyc / 3) % 2) == 0) : 1'b1;
      if (stalled) begin
        check({tag, " stall valid"}, dump_valid, 1);
        check({tag, " stall addr"}, dump_addr, s_addr);
        check({tag, " stall hash"}, dump_hash, s_hash);
        check({tag, " stall occ"}, dump_occurr, s_occ);
      end
      stalled = 0;
      if (dump_valid) begin
        if (dump_ready) begin
          if (idx < exp_q.size()) begin
            a = exp_q[idx];
            check({tag, " addr"}, dump_addr, a);
            check({tag, " hash"}, dump_hash, ref_hash[a]);
            check({tag, " occ"}, dump_occurr, ref_occ[a]);
          end
          idx++;
        end else begin
          stalled = 1;
          s_addr  = dump_addr;
          s_hash  = dump_hash;
          s_occ   = dump_occurr;
        end
      end
      step();
      cyc++;
      if (dump_done) begin
        done = 1;
        check({tag, " ready with done"}, table_ready, 1);
      end
    end
    check({tag, " done seen"}, done, 1);
    check({tag, " entry count"}, idx, exp_q.size());
    step();
    check({tag, " done single pulse"}, dump_done, 0);
    dump_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    int vld;
    bit reached;
    logic [AW-1:0] ra;

    // Reset state and the power-on clear
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    wait_clear("por");
    access(8'h55, 1'b0, '0, '0);

    // Same-cycle write/read bypass, neighbour untouched
    access(8'h10, 1'b1, 32'hDEADBEEF, 32'd3);
    access(8'h11, 1'b0, '0, '0);
    access(8'h10, 1'b0, '0, '0);

    // Simultaneous clear and dump: clear wins, no dump output
    clear_req = 1'b1;
    dump_req  = 1'b1;
    step();
    clear_req = 1'b0;
    dump_req  = 1'b0;
    wait_clear("clr+dump");
    access(8'h10, 1'b0, '0, '0);

    // Sparse table dump with the host always ready
    access(8'h00, 1'b1, 32'hA, 32'd1);
    access(8'hFF, 1'b1, 32'hB, 32'd2);
    run_dump("dump1", 1'b0);

    // Random core traffic, then a back-pressured dump
    for (int i = 0; i < 40; i++)
      access(AW'($urandom_range(0, DEPTH - 1)), 1'($urandom_range(0, 1)),
             W'($urandom), W'($urandom_range(0, 3)));
    access(8'd40, 1'b1, W'($urandom), 32'd5);
    run_dump("dump2", 1'b1);
    for (int i = 0; i < 5; i++) begin
      ra = AW'($urandom_range(0, DEPTH - 1));
      access(ra, 1'b0, '0, '0);
    end

    // Reset in the middle of a dump at pointer 40
    dump_req = 1'b1;
    step();
    dump_req   = 1'b0;
    dump_ready = 1'b1;
    cyc = 0;
    while (!(dump_valid && dump_addr == 8'd40) && cyc < 2000) begin
      step();
      cyc++;
    end
    reached = dump_valid && (dump_addr == 8'd40);
    check("rst40 reached", reached, 1);
    rst = 1'b1;
    #1;
    check_all_zero("rst40");
    dump_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_clear("rst40");
    vld = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (dump_valid) vld++;
    end
    check("rst40 no resume", vld, 0);
    check("rst40 ready", table_ready, 1);
    access(8'd40, 1'b0, '0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hash_occurr_table.md
# hash_occurr_table

Storage and responder for the hash and occurrence arrays driven by the hash core. Serves its single-cycle address and read-modify-write traffic: the core presents `HashOccurrAddr`, the table returns `HashValue`/`OccurrValue`, and the core writes back with `WrEn`. The block also provides a host-side clear engine and a dump engine that streams the finished table out over a valid/ready handshake. It sits between the hash core and the AXI-facing result readout.

## Interface
- `DATA_INDEX_WIDTH`, default 32: width of each hash and occurrence word.
- `BIT_ON_TAILS`, default 7: derives address width `ADDR_W = BIT_ON_TAILS+1` and depth `DEPTH = 1<<ADDR_W` (256 entries by default).

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `HashOccurrAddr`  in  ADDR_W  core read/write address.
- `HashValue`  out  DATA_INDEX_WIDTH  registered hash word at the last sampled address.
- `OccurrValue`  out  DATA_INDEX_WIDTH  registered occurrence count at the last sampled address.
- `WrEn`  in  1  core write strobe.
- `NewHashValue`  in  DATA_INDEX_WIDTH  hash write data.
- `NewOccurrValue`  in  DATA_INDEX_WIDTH  occurrence write data.
- `table_ready`  out  1  high only in IDLE; the core must not access the table while it is low.
- `clear_req`  in  1  one-cycle request to zero the table.
- `dump_req`  in  1  one-cycle request to stream the table.
- `dump_valid`  out  1  dump entry valid.
- `dump_ready`  in  1  host accepts the entry.
- `dump_addr`  out  ADDR_W  entry address.
- `dump_hash`  out  DATA_INDEX_WIDTH  entry hash word.
- `dump_occurr`  out  DATA_INDEX_WIDTH  entry occurrence word.
- `dump_done`  out  1  one-cycle pulse when the dump walk finishes.

## Operation
- Storage: two `DEPTH`-entry synchronous RAMs sharing one address. Contents are not reset.
- States: CLEAR, IDLE, DUMP_RD, DUMP_OUT.
- Reset value of every output is 0. Reset forces CLEAR with the clear pointer at 0.
- A reset asserted mid-operation aborts any dump and restarts a full clear.
- CLEAR:
  - Writes zero to both arrays at pointer p, then increments p.
  - After p = DEPTH-1 is written, the block goes to IDLE.
  - Core `WrEn` is ignored.
- IDLE:
  - Each edge registers `HashValue`/`OccurrValue` from `HashOccurrAddr`.
  - If `WrEn` is high, the new data is written at that address.
  - On a same-address read and write in the same cycle, the outputs show the new data (write-first).
  - `clear_req` moves the block to CLEAR.
  - Otherwise `dump_req` moves it to DUMP_RD with the pointer at 0.
  - If both are high, clear wins and the dump request is dropped.
  - `WrEn` in the same cycle as an accepted request is still performed.
- DUMP_RD:
  - Issues a read at the pointer.
  - On the next edge, loads the `dump_*` registers and raises `dump_valid` (DUMP_OUT).
- DUMP_OUT:
  - Holds `dump_*` stable while `dump_valid && !dump_ready`.
  - On a handshake at pointer DEPTH-1, drops valid, pulses `dump_done`, and returns to IDLE.
  - On any other handshake, increments the pointer and returns to DUMP_RD.
- `clear_req`/`dump_req` outside IDLE are ignored.
- `HashValue`/`OccurrValue` hold their last value outside IDLE.
- Occurrence values are stored verbatim. The table performs no arithmetic and no wrap handling; saturation is the core's responsibility.

## Timing
- Core read latency is 1 cycle: address at edge n gives data valid after edge n.
- A write issued at edge n is visible on a read issued at edge n+1, or at edge n itself through the bypass.
- Clear takes exactly DEPTH cycles. `table_ready` rises after edge DEPTH following reset release or request acceptance.
- Dump takes at least 2 cycles per entry: one read cycle plus one output cycle, stretched by `dump_ready` back-pressure.
- `dump_done` is high for the single cycle after the final handshake. `table_ready` is high in that same cycle.

## Configuration
- `HASH_TABLE_SKIP_EMPTY_EN`:
  - Defined: in DUMP_RD, entries with occurrence 0 are not presented. The pointer advances with no valid, costing 1 cycle per skipped entry.
  - Defined, last entry empty: if entry DEPTH-1 is empty, the dump finishes and `dump_done` pulses without a final valid.
  - Undefined: all DEPTH entries are presented in address order.

## Test plan
- Reset, then release: `table_ready` = 0 for 256 cycles, 1 from cycle 256. A read of address 0x55 afterwards returns hash 0 and occurrence 0.
- In IDLE, write address 0x10 with hash 0xDEADBEEF and occurrence 3 while reading 0x10 in the same cycle: outputs next cycle are 0xDEADBEEF and 3. A read of 0x11 returns 0.
- Write 0x00 (hash 0xA, occurrence 1) and 0xFF (hash 0xB, occurrence 2), then pulse `dump_req` with `dump_ready` high:
  - Macro undefined: 256 handshakes with addresses 0..255, entry 0xFF carrying 0xB/2, then one `dump_done` pulse.
  - Macro defined: exactly 2 handshakes, at addresses 0x00 and 0xFF.
- Dump with `dump_ready` toggling every 3 cycles: `dump_*` stays stable while stalled, and no entry is duplicated or lost.
- `clear_req` and `dump_req` high together in IDLE: clear runs for 256 cycles, no `dump_valid` ever, and previously written entries read 0 afterwards.
- Assert `rst` during a dump at pointer 40: all outputs go to 0 immediately. After release, a full 256-cycle clear runs and the dump does not resume.
